// File: rtl/mmio_console.sv
// Memory-mapped console: TXDATA bytes queue in a FIFO and are serialised 8N1 on tx_o.
// Register window of four words at BASE_ADDR; reads return one cycle after the address.
module mmio_console #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic        wen_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        hit_o,
  output logic        tx_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Bus decode
  logic       hit;
  logic [1:0] offset;
  logic       bus_wr;
  logic       push_req;
  logic       ovf_clr;

  assign hit      = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign offset   = addr_i[3:2];
  assign bus_wr   = wen_i && hit;
  assign push_req = bus_wr && (offset == 2'd0);
  assign ovf_clr  = bus_wr && (offset == 2'd1) && data_in_i[3];

  // Bits the register map never looks at
  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], data_in_i[31:16]};

  // Control registers
  logic        tx_en_q;
  logic [15:0] baud_q;
  logic        ovf_q;

  // FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          full, empty, push, pop;

  assign full  = (level_q == LW'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  // Fullness is judged before any same-cycle pop
  assign push  = push_req && !full;

  // Transmitter
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy;

  assign busy = (state_q != StIdle);

  // Control register writes; a same-cycle overflow beats a clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_en_q <= 1'b0;
      baud_q  <= DEFAULT_DIV;
      ovf_q   <= 1'b0;
    end else begin
      if (bus_wr && offset == 2'd2) baud_q  <= data_in_i[15:0];
      if (bus_wr && offset == 2'd3) tx_en_q <= data_in_i[0];
      if (push_req && full) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // FIFO storage, no reset needed since level gates every read
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= data_in_i[7:0];
  end

  // FIFO pointers and level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) begin
        level_q <= level_q + LW'(1);
      end else if (pop && !push) begin
        level_q <= level_q - LW'(1);
      end
    end
  end

  // Transmit FSM state, bit timer, shifter and registered line
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Next-state: each bit lasts baud_q+1 clocks, timer reloads at every bit start
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (tx_en_q && !empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          cnt_d   = baud_q;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          state_d = StData;
          idx_d   = '0;
          cnt_d   = baud_q;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          cnt_d = baud_q;
          if (idx_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more data waits
          if (tx_en_q && !empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            cnt_d   = baud_q;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            tx_d    = 1'b1;
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read mux for the addressed register
  logic [31:0] rdata;
  always_comb begin
    rdata = '0;
    unique case (offset)
      2'd0: rdata = '0;
      2'd1: rdata = {16'h0, 8'(level_q), 4'h0, ovf_q, busy, empty, full};
      2'd2: rdata = {16'h0, baud_q};
      2'd3: rdata = {31'h0, tx_en_q};
      default: rdata = '0;
    endcase
  end

  // Registered read data and hit, matching data-memory latency
  logic [31:0] data_out_q;
  logic        hit_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_out_q <= '0;
      hit_q      <= 1'b0;
    end else begin
      data_out_q <= (hit && !wen_i) ? rdata : 32'h0;
      hit_q      <= hit;
    end
  end

  assign data_out_o = data_out_q;
  assign hit_o      = hit_q;
  assign tx_o       = tx_q;

endmodule
